// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: opcode constants, FSM state type and default sizes for alu_sched.
package alu_sched_pkg;
    localparam int DEF_WIDTH = 128;
    localparam int DEF_SHW   = 5;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SGT = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
endpackage

// File: rtl/alu_sched_if.sv
// alu_sched_if: two-requester request bus plus single response channel of alu_sched.
interface alu_sched_if
    import alu_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [7:0]         req_opcode;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [2*SHW-1:0]   req_shift;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_result;
    logic               rsp_carry;
    logic               rsp_zero;
    logic               rsp_ovf;
    logic               rsp_err;
    logic [15:0]        ops_done;
    modport master (
        output req_valid, req_opcode, req_a, req_b, req_shift, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_err, ops_done
    );
    modport slave (
        input  req_valid, req_opcode, req_a, req_b, req_shift, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_err, ops_done
    );
endinterface

// File: rtl/alu_sched_exec.sv
// alu_sched_exec: combinational ALU datapath; SGT/SLT exist only with ALU_SCHED_CMP_EN defined.
module alu_sched_exec
    import alu_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shift,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             err
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_SLL: result = a << shift;
            OP_SRL: result = a >> shift;
`ifdef ALU_SCHED_CMP_EN
            OP_SGT: result = {{(WIDTH-1){1'b0}}, $signed(a) > $signed(b)};
            OP_SLT: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
`endif
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin two-requester ALU scheduler (IDLE/BUSY/DONE) with response backpressure.
// Optional SGT/SLT support via ALU_SCHED_CMP_EN, implemented in alu_sched_exec.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input logic        clk,
    input logic        rst,
    alu_sched_if.slave bus
);
    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             id_q, id_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [SHW-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [15:0]      done_q, done_d;
    logic             gnt_any;
    logic             gnt_id;
    logic [WIDTH-1:0] ex_res;
    logic             ex_carry, ex_ovf, ex_err;

    // prio_q names the requester favoured when both are valid
    assign gnt_any = |bus.req_valid;
    assign gnt_id  = (&bus.req_valid) ? prio_q : bus.req_valid[1];

    alu_sched_exec #(.WIDTH(WIDTH), .SHW(SHW)) u_exec (
        .opcode (op_q),
        .a      (a_q),
        .b      (b_q),
        .shift  (sh_q),
        .result (ex_res),
        .carry  (ex_carry),
        .ovf    (ex_ovf),
        .err    (ex_err)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: if (gnt_any) begin
                state_d = S_BUSY;
                prio_d  = ~gnt_id;
                id_d    = gnt_id;
                op_d    = gnt_id ? bus.req_opcode[7:4] : bus.req_opcode[3:0];
                a_d     = gnt_id ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
                b_d     = gnt_id ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
                sh_d    = gnt_id ? bus.req_shift[2*SHW-1:SHW] : bus.req_shift[SHW-1:0];
            end
            S_BUSY: begin
                state_d = S_DONE;
                res_d   = ex_res;
                carry_d = ex_carry;
                zero_d  = (ex_res == '0);
                ovf_d   = ex_ovf;
                err_d   = ex_err;
            end
            S_DONE: if (bus.rsp_ready) begin
                state_d = S_IDLE;
                done_d  = done_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // ready is held low while rst is asserted even though the state already reads IDLE
    assign bus.req_ready  = (state_q == S_IDLE && !rst && gnt_any) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid  = (state_q == S_DONE);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_ovf    = ovf_q;
    assign bus.rsp_err    = err_q;
    assign bus.ops_done   = done_q;
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed self-checking bench for alu_sched (honours ALU_SCHED_CMP_EN).
module tb_alu_sched;
    import alu_sched_pkg::*;
    localparam int W = 128;
    localparam int S = 5;
    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_sched_if #(.WIDTH(W), .SHW(S)) bus ();
    alu_sched #(.WIDTH(W), .SHW(S)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int r, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [S-1:0] sh);
        bus.req_opcode[4*r +: 4] = op;
        bus.req_a[W*r +: W]      = a;
        bus.req_b[W*r +: W]      = b;
        bus.req_shift[S*r +: S]  = sh;
        bus.req_valid[r]         = 1'b1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && bus.req_ready == 2'b00; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_vld", {127'd0, bus.rsp_valid}, 0);
        check("rst_done", {112'd0, bus.ops_done}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one isolated operation; flags are packed {id, carry, zero, ovf, err}
    task automatic single(input string tag, input int r, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [S-1:0] sh, input logic [W-1:0] er, input logic ec, input logic ez, input logic eo, input logic ee);
        @(negedge clk);
        drive(r, op, a, b, sh);
        #1;
        wait_ready();
        check({tag, "_rdy"}, {126'd0, bus.req_ready}, (r == 1) ? 2 : 1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        check({tag, "_busy"}, {127'd0, bus.rsp_valid}, 0);
        @(negedge clk);
        #1;
        check({tag, "_vld"}, {127'd0, bus.rsp_valid}, 1);
        check({tag, "_res"}, bus.rsp_result, er);
        check({tag, "_flags"}, {123'd0, bus.rsp_id, bus.rsp_carry, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err},
              {123'd0, r[0], ec, ez, eo, ee});
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        check({tag, "_ack"}, {127'd0, bus.rsp_valid}, 0);
    endtask

    initial begin
        bus.req_valid  = 2'b00;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_shift  = '0;
        bus.rsp_ready  = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        bus.req_valid = 2'b11;
        #11;
        check("init_rdy", {126'd0, bus.req_ready}, 0);
        check("init_vld", {127'd0, bus.rsp_valid}, 0);
        check("init_res", bus.rsp_result, 0);
        check("init_done", {112'd0, bus.ops_done}, 0);
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst = 1'b0;

        single("add", 0, OP_ADD, ONES, 1, 0, 0, 1, 1, 0, 0);
        check("done1", {112'd0, bus.ops_done}, 1);
        single("sub", 1, OP_SUB, ~MSB, ONES, 0, MSB, 1, 0, 1, 0);
        single("ill9", 0, 4'd9, 123, 45, 0, 0, 0, 1, 0, 1);
`ifdef ALU_SCHED_CMP_EN
        single("slt", 0, OP_SLT, ONES, 0, 0, 1, 0, 0, 0, 0);
        single("sgt", 1, OP_SGT, 5, ONES, 0, 1, 0, 0, 0, 0);
`else
        single("slt", 0, OP_SLT, ONES, 0, 0, 0, 0, 1, 0, 1);
        single("sgt", 1, OP_SGT, 5, ONES, 0, 0, 0, 1, 0, 1);
`endif
        single("sll", 1, OP_SLL, 1, 0, 31, 128'h8000_0000, 0, 0, 0, 0);
        single("srl", 0, OP_SRL, MSB, 0, 4, MSB >> 4, 0, 0, 0, 0);
        single("and0", 1, OP_AND, 128'hF0, 128'h0F, 0, 0, 0, 1, 0, 0);
        single("or", 0, OP_OR, 128'hF0, 128'h0C, 0, 128'hFC, 0, 0, 0, 0);
        check("done9", {112'd0, bus.ops_done}, 9);

        reset_pulse();
        drive(0, OP_ADD, 5, 3, 0);
        drive(1, OP_SUB, 5, 3, 0);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            wait_ready();
            check("cont_gnt", {126'd0, bus.req_ready}, k[0] ? 2 : 1);
            wait_rsp();
            check("cont_id", {127'd0, bus.rsp_id}, {127'd0, k[0]});
            check("cont_res", bus.rsp_result, k[0] ? 2 : 8);
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        #1;
        check("cont_done", {112'd0, bus.ops_done}, 4);

        @(negedge clk);
        drive(1, OP_OR, 128'hF0, 128'h0F, 0);
        #1;
        wait_ready();
        check("bp_gnt", {126'd0, bus.req_ready}, 2);
        @(negedge clk);
        bus.req_valid = 2'b01;
        #1;
        wait_rsp();
        for (int k = 0; k < 5; k++) begin
            check("bp_vld", {127'd0, bus.rsp_valid}, 1);
            check("bp_res", bus.rsp_result, 128'hFF);
            check("bp_rdy", {126'd0, bus.req_ready}, 0);
            check("bp_id", {127'd0, bus.rsp_id}, 1);
            @(negedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b00;
        #1;
        check("bp_rel", {127'd0, bus.rsp_valid}, 0);
        check("bp_done", {112'd0, bus.ops_done}, 5);

        reset_pulse();
        drive(0, OP_ADD, 1, 1, 0);
        #1;
        wait_ready();
        check("rb_gnt", {126'd0, bus.req_ready}, 1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst = 1'b1;
        #1;
        check("rb_rdy", {126'd0, bus.req_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("rb_novld", {127'd0, bus.rsp_valid}, 0);
        end
        check("rb_done", {112'd0, bus.ops_done}, 0);
        drive(0, OP_ADD, 2, 2, 0);
        drive(1, OP_ADD, 7, 7, 0);
        #1;
        check("rb_gnt0", {126'd0, bus.req_ready}, 1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        wait_rsp();
        check("rb_id", {127'd0, bus.rsp_id}, 0);
        check("rb_res", bus.rsp_result, 4);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        check("rb_done1", {112'd0, bus.ops_done}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
